psimd_addsub_pipe: RTL and testbench
====================================

Name: psimd_addsub_pipe

Overview:
- Parametrised, pipelined packed-SIMD saturating add/subtract unit; next generation of the ALU's fixed 4x4-bit packed saturating add.
- Adds lane count, lane width, signed/unsigned add/sub modes, per-lane and sticky saturation flags, and a valid/ready elastic pipeline.
- Sits between the ALU operand muxes and the writeback path; usable stalled or free-running.

Parameters:
- LANE_W, 4, bits per lane (>=2).
- LANES, 4, number of lanes (>=1); data width DW = LANES*LANE_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  DW  operand A; lane i = bits [i*LANE_W +: LANE_W], lane 0 least significant.
- b  in  DW  operand B, same packing.
- mode  in  2  00 signed add, 01 signed sub, 10 unsigned add, 11 unsigned sub.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- sum  out  DW  packed saturated result.
- sat_lanes  out  LANES  bit i set if lane i of sum saturated.
- sat_clr  in  1  clears sat_sticky.
- sat_sticky  out  1  set once any accepted result saturated.

Behaviour:
- Reset (rst_n low at edge): s1_valid, out_valid, sum, sat_lanes, sat_sticky all 0; in-flight beats discarded, none emitted afterwards.
- Two register stages. S1 captures a, b, mode on in_valid && in_ready. S2 computes lanes from S1 and registers sum and sat_lanes. Latency exactly 2 cycles with out_ready held high.
- Elastic rules: S2 loads when s1_valid && (!out_valid || out_ready). in_ready = !s1_valid || S2 loads this cycle. Full throughput of 1 beat/cycle under out_ready=1. Maximum 2 beats buffered.
- While out_valid && !out_ready, sum and sat_lanes are held stable. No drop, duplication or reordering.
- Lane arithmetic is independent per lane; no carry or borrow crosses lanes.
  - Signed add: overflow if sign(a)==sign(b) and sign(raw)!=sign(a). Clamp to 0111..1 if a is non-negative, else 1000..0.
  - Signed sub (a-b): overflow if sign(a)!=sign(b) and sign(raw)!=sign(a). Same clamp rule, keyed on sign(a).
  - Unsigned add: carry-out clamps to all ones.
  - Unsigned sub: borrow clamps to all zeros.
  - Non-saturating lanes output raw LANE_W-bit result; sat_lanes bit set only on clamp.
- sat_sticky is set when S2 loads a beat with any sat_lanes bit set. sat_clr clears it. If clear and set occur in the same cycle, set wins.

Optional Feature:
- Macro PSIMD_SAT_CNT_EN.
- Defined: adds output sat_cnt [15:0], counting S2 loads with any saturated lane. Counter saturates at 16'hFFFF, is cleared by sat_clr (increment wins on collision), and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package psimd_pkg holds the mode encodings MODE_SADD=2'b00, MODE_SSUB=2'b01, MODE_UADD=2'b10, MODE_USUB=2'b11, plus a helper for signed max/min constants of LANE_W.
- One natural sub-module, psimd_sat_lane. It is combinational, parametrised by LANE_W, takes a lane, b lane and mode, and returns the lane result and sat bit. It is generated LANES times inside the S2 logic.

Test Plan:
- Mode 00, a=16'h7381, b=16'h12F1 -> after 2 cycles sum=16'h7582, sat_lanes=4'b1010, sat_sticky=1.
- Mode 01, a=16'h8705, b=16'h1F13 -> sum=16'h87F2, sat_lanes=4'b1100.
- Mode 10, a=16'hF809, b=16'h1806 -> sum=16'hFF0F, sat_lanes=4'b1100. Mode 11, a=16'h209F, b=16'h314F -> sum=16'h0050, sat_lanes=4'b1100.
- Backpressure: in_valid high with a counting beat stream, out_ready low 5 cycles. Exactly 2 beats accepted, then in_ready=0. On release, beats emerge in order with no gaps, loss or duplicates.
- sat_clr asserted the same cycle a saturating beat loads -> sat_sticky stays 1. Next cycle, sat_clr with a clean beat -> sat_sticky=0. rst_n low mid-stream -> out_valid=0 the next cycle and no stale beat after release.
- LANE_W=8, LANES=2, mode 00, a=16'h7F80, b=16'h01FF -> sum=16'h7F80, sat_lanes=2'b11. With PSIMD_SAT_CNT_EN, sat_cnt increments by 1 per such beat.

Source files
------------

// File: rtl/psimd_pkg.sv
// Shared definitions for the packed-SIMD saturating add/sub unit:
// mode encodings and signed clamp constants for a given lane width.
package psimd_pkg;

  localparam logic [1:0] MODE_SADD = 2'b00;
  localparam logic [1:0] MODE_SSUB = 2'b01;
  localparam logic [1:0] MODE_UADD = 2'b10;
  localparam logic [1:0] MODE_USUB = 2'b11;

  // Largest positive two's-complement value of a w-bit lane (0111..1).
  function automatic logic [63:0] smax_const(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit lane (1000..0).
  function automatic logic [63:0] smin_const(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/psimd_sat_lane.sv
// One lane of saturating add/subtract, purely combinational.
// Overflow detection is on the lane's own bits only; nothing crosses lanes.
module psimd_sat_lane
  import psimd_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [1:0]        mode,
  output logic [LANE_W-1:0] res,
  output logic              sat
);

  localparam logic [LANE_W-1:0] SMAX = LANE_W'(smax_const(LANE_W));
  localparam logic [LANE_W-1:0] SMIN = LANE_W'(smin_const(LANE_W));

  logic [LANE_W:0] raw;
  logic            sa;
  logic            sb;
  logic            sr;

  always_comb begin
    raw = mode[0] ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    sa  = a[LANE_W-1];
    sb  = b[LANE_W-1];
    sr  = raw[LANE_W-1];
    res = raw[LANE_W-1:0];
    sat = 1'b0;
    unique case (mode)
      MODE_SADD: sat = (sa == sb) && (sr != sa);
      MODE_SSUB: sat = (sa != sb) && (sr != sa);
      // raw[LANE_W] is carry-out for add and borrow for sub
      MODE_UADD: sat = raw[LANE_W];
      MODE_USUB: sat = raw[LANE_W];
    endcase
    if (sat) begin
      unique case (mode)
        MODE_SADD, MODE_SSUB: res = sa ? SMIN : SMAX;
        MODE_UADD:            res = '1;
        MODE_USUB:            res = '0;
      endcase
    end
  end

endmodule

// File: rtl/psimd_addsub_pipe.sv
// Two-stage elastic packed-SIMD saturating add/sub unit with sticky saturation flag.
// Define PSIMD_SAT_CNT_EN to add the 16-bit saturating sat_cnt output.
module psimd_addsub_pipe
  import psimd_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 4,
  localparam int DW    = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    sum,
  output logic [LANES-1:0] sat_lanes,
  input  logic             sat_clr,
`ifdef PSIMD_SAT_CNT_EN
  output logic [15:0]      sat_cnt,
`endif
  output logic             sat_sticky
);

  logic             s1_valid_reg;
  logic [DW-1:0]    s1_a_reg;
  logic [DW-1:0]    s1_b_reg;
  logic [1:0]       s1_mode_reg;
  logic             out_valid_reg;
  logic [DW-1:0]    sum_reg;
  logic [LANES-1:0] sat_lanes_reg;
  logic             sat_sticky_reg;

  logic             s1_load;
  logic             s2_load;
  logic             any_sat;
  logic [DW-1:0]    lane_res;
  logic [LANES-1:0] lane_sat;

  // S2 can take a new beat whenever its current one leaves (or it is empty).
  assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign any_sat  = |lane_sat;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      psimd_sat_lane #(
        .LANE_W(LANE_W)
      ) u_lane (
        .a   (s1_a_reg[gi*LANE_W +: LANE_W]),
        .b   (s1_b_reg[gi*LANE_W +: LANE_W]),
        .mode(s1_mode_reg),
        .res (lane_res[gi*LANE_W +: LANE_W]),
        .sat (lane_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_mode_reg    <= MODE_SADD;
      out_valid_reg  <= 1'b0;
      sum_reg        <= '0;
      sat_lanes_reg  <= '0;
      sat_sticky_reg <= 1'b0;
    end else begin
      s1_valid_reg  <= s1_load || (s1_valid_reg && !s2_load);
      out_valid_reg <= s2_load || (out_valid_reg && !out_ready);
      if (s1_load) begin
        s1_a_reg    <= a;
        s1_b_reg    <= b;
        s1_mode_reg <= mode;
      end
      if (s2_load) begin
        sum_reg       <= lane_res;
        sat_lanes_reg <= lane_sat;
      end
      // A saturating load outranks a simultaneous clear.
      if (s2_load && any_sat) begin
        sat_sticky_reg <= 1'b1;
      end else if (sat_clr) begin
        sat_sticky_reg <= 1'b0;
      end
    end
  end

`ifdef PSIMD_SAT_CNT_EN
  logic [15:0] sat_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_cnt_reg <= '0;
    end else if (s2_load && any_sat) begin
      if (sat_cnt_reg != 16'hFFFF) begin
        sat_cnt_reg <= sat_cnt_reg + 16'd1;
      end
    end else if (sat_clr) begin
      sat_cnt_reg <= '0;
    end
  end

  assign sat_cnt = sat_cnt_reg;
`endif

  assign out_valid  = out_valid_reg;
  assign sum        = sum_reg;
  assign sat_lanes  = sat_lanes_reg;
  assign sat_sticky = sat_sticky_reg;

endmodule

// File: tb/tb_psimd_addsub_pipe.sv
// Bench for psimd_addsub_pipe: directed vectors, elastic corner cases and a
// randomized run checked against an integer-arithmetic lane model.
module tb_psimd_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, sat_clr, sat_sticky;
  logic [15:0] a, b, sum;
  logic [1:0]  mode;
  logic [3:0]  sat_lanes;

  logic        in_valid2, in_ready2, out_valid2, sat_sticky2;
  logic [15:0] a2, b2, sum2;
  logic [1:0]  sat_lanes2;
`ifdef PSIMD_SAT_CNT_EN
  logic [15:0] sat_cnt, sat_cnt2;
`endif

  always #5 clk = ~clk;

  psimd_addsub_pipe #(.LANE_W(4), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .sat_lanes(sat_lanes), .sat_clr(sat_clr),
`ifdef PSIMD_SAT_CNT_EN
    .sat_cnt(sat_cnt),
`endif
    .sat_sticky(sat_sticky)
  );

  psimd_addsub_pipe #(.LANE_W(8), .LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .mode(2'b00), .out_valid(out_valid2), .out_ready(1'b1),
    .sum(sum2), .sat_lanes(sat_lanes2), .sat_clr(1'b0),
`ifdef PSIMD_SAT_CNT_EN
    .sat_cnt(sat_cnt2),
`endif
    .sat_sticky(sat_sticky2)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [15:0] sum;
    logic [3:0]  sat;
  } vec_t;

  vec_t        vecs[4];
  int          tests = 0;
  int          fails = 0;
  logic [19:0] exp_q[$];
  int          acc_cnt, out_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane model: exact integer result, then clamp to the lane's numeric range.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic [1:0] m);
    logic [15:0] s;
    logic [3:0]  st;
    logic [31:0] rv;
    int xv, yv, r, lo, hi;
    s = '0;
    st = '0;
    for (int i = 0; i < 4; i++) begin
      xv = int'(x[i*4 +: 4]);
      yv = int'(y[i*4 +: 4]);
      if (!m[1]) begin
        if (xv >= 8) xv -= 16;
        if (yv >= 8) yv -= 16;
        lo = -8; hi = 7;
      end else begin
        lo = 0; hi = 15;
      end
      r = m[0] ? xv - yv : xv + yv;
      if (r > hi) begin r = hi; st[i] = 1'b1; end
      if (r < lo) begin r = lo; st[i] = 1'b1; end
      rv = r;
      s[i*4 +: 4] = rv[3:0];
    end
    return {st, s};
  endfunction

  // One clock of the streaming engine; entered and left at a negedge.
  task automatic cycle();
    logic [19:0] head;
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        head = exp_q[0];
        chk("stream_beat", {12'd0, sat_lanes, sum}, {12'd0, head});
        if (out_ready) begin
          void'(exp_q.pop_front());
          out_cnt++;
        end
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, mode));
      acc_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{16'h7381, 16'h12F1, 2'b00, 16'h7582, 4'b1010};
    vecs[1] = '{16'h8705, 16'h1F13, 2'b01, 16'h87F2, 4'b1100};
    vecs[2] = '{16'hF809, 16'h1806, 2'b10, 16'hFF0F, 4'b1100};
    vecs[3] = '{16'h209F, 16'h314F, 2'b11, 16'h0050, 4'b1100};

    rst_n = 1'b0; in_valid = 0; out_ready = 1; sat_clr = 0;
    a = 0; b = 0; mode = 0; in_valid2 = 0; a2 = 0; b2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_sat_lanes", 32'(sat_lanes), 0);
    chk("rst_sticky", 32'(sat_sticky), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors: exact 2-cycle latency, sticky cleared before each.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; a = vecs[i].a; b = vecs[i].b; mode = vecs[i].mode; sat_clr = 1;
      @(negedge clk);
      in_valid = 0; sat_clr = 0;
      chk("vec_lat1_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("vec_valid", 32'(out_valid), 1);
      chk("vec_sum", 32'(sum), 32'(vecs[i].sum));
      chk("vec_sat", 32'(sat_lanes), 32'(vecs[i].sat));
      chk("vec_sticky", 32'(sat_sticky), 32'(|vecs[i].sat));
      $display("[TB] vec %0d mode=%b a=%h b=%h -> sum=%h sat=%b", i, vecs[i].mode,
               vecs[i].a, vecs[i].b, sum, sat_lanes);
      @(negedge clk);
      chk("vec_drained", 32'(out_valid), 0);
    end

    // Backpressure: counting stream, consumer stalled 5 cycles.
    acc_cnt = 0; out_cnt = 0; exp_q.delete();
    mode = 2'b10; b = 0; out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; a = 16'(acc_cnt + 1);
      cycle();
    end
    chk("bp_accepted", 32'(acc_cnt), 2);
    chk("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (acc_cnt < 8); a = 16'(acc_cnt + 1);
      #1;
      if (exp_q.size() != 0) chk("bp_no_gap", 32'(out_valid), 1);
      #0 cycle();
    end
    in_valid = 0;
    chk("bp_sent", 32'(acc_cnt), 8);
    chk("bp_recv", 32'(out_cnt), 8);
    $display("[TB] backpressure: accepted=%0d delivered=%0d", acc_cnt, out_cnt);

    // sat_clr colliding with a saturating load: set wins; then clear applies.
    sat_clr = 1; @(negedge clk); @(negedge clk);
    chk("clr_pre", 32'(sat_sticky), 0);
    in_valid = 1; a = vecs[0].a; b = vecs[0].b; mode = vecs[0].mode; sat_clr = 0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; mode = 2'b10; sat_clr = 1;
    @(negedge clk);
    in_valid = 0;
    chk("clr_collide_sticky", 32'(sat_sticky), 1);
    @(negedge clk);
    sat_clr = 0;
    chk("clr_clean_sticky", 32'(sat_sticky), 0);
    chk("clr_clean_sum", 32'(sum), 32'h0002);
    $display("[TB] sticky collision sequence done, sticky=%b", sat_sticky);
    @(negedge clk);

    // Randomized traffic against the model.
    acc_cnt = 0; out_cnt = 0; exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a = 16'($urandom); b = 16'($urandom); mode = 2'($urandom);
      cycle();
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 6; c++) cycle();
    chk("rand_drain", 32'(exp_q.size()), 0);
    chk("rand_count", 32'(out_cnt), 32'(acc_cnt));
    $display("[TB] random: %0d beats in, %0d beats out", acc_cnt, out_cnt);

    // Reset mid-stream: nothing stale may emerge afterwards.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; a = 16'($urandom); b = 16'($urandom); mode = 2'($urandom);
      cycle();
    end
    in_valid = 0; rst_n = 0;
    @(negedge clk);
    exp_q.delete();
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_sticky", 32'(sat_sticky), 0);
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("postrst_idle", 32'(out_valid), 0);
      #0 cycle();
    end
    $display("[TB] mid-stream reset: out_valid=%b", out_valid);

    // 8-bit x 2-lane instance, two back-to-back saturating beats.
    in_valid2 = 1; a2 = 16'h7F80; b2 = 16'h01FF;
    @(negedge clk);
    @(negedge clk);
    in_valid2 = 0;
    chk("w8_valid", 32'(out_valid2), 1);
    chk("w8_sum", 32'(sum2), 32'h7F80);
    chk("w8_sat", 32'(sat_lanes2), 32'h3);
    chk("w8_sticky", 32'(sat_sticky2), 1);
    @(negedge clk);
    chk("w8_second", 32'({out_valid2, sum2}), 32'h17F80);
`ifdef PSIMD_SAT_CNT_EN
    chk("w8_sat_cnt", 32'(sat_cnt2), 2);
`endif
    $display("[TB] w8 a=7f80 b=01ff -> sum=%h sat=%b", sum2, sat_lanes2);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
